qpi_mem_arb: RTL

- Round-robin arbiter that shares one QPI memory controller command/data interface between N burst requesters.
- Typical requesters: the video frame grabber (64-word write bursts) and a display/readout or CPU DMA engine.
- Grants one requester at a time and forwards its command.
- Steers write-data acknowledges and read-data strobes to the granted requester only.
- Holds the grant until the burst's last data beat completes.

---
 rtl/qpi_mem_arb.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/qpi_mem_arb.sv
// qpi_mem_arb: round-robin arbiter sharing one QPI memory controller
// command/data port between N burst requesters. The grant is held from
// command issue until the burst's terminal data beat; all data paths are
// purely combinational steering, with no added pipeline latency.
// GW must be wide enough to index N requesters.

module qpi_mem_arb #(
    parameter int N  = 2,
    parameter int GW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*22-1:0]   req_addr,
    input  logic [N*7-1:0]    req_len,
    input  logic [N-1:0]      req_rw,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [N*32-1:0]   req_wdata,
    output logic [N-1:0]      req_wack,
    output logic [N-1:0]      req_wlast,
    output logic [31:0]       req_rdata,
    output logic [N-1:0]      req_rstb,
    output logic [N-1:0]      req_rlast,
    output logic [21:0]       mi_addr,
    output logic [6:0]        mi_len,
    output logic              mi_rw,
    output logic              mi_valid,
    input  logic              mi_ready,
    output logic [31:0]       mi_wdata,
    input  logic              mi_wack,
    input  logic              mi_wlast,
    input  logic [31:0]       mi_rdata,
    input  logic              mi_rstb,
    input  logic              mi_rlast,
    output logic              busy,
    output logic [GW-1:0]     grant
);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t          state;
    logic [GW-1:0]   ptr;
    logic            rw_q;

    logic            sel_valid;
    logic [21:0]     sel_addr;
    logic [6:0]      sel_len;
    logic            sel_rw;
    logic [31:0]     sel_wdata;

    logic            pick_found;
    logic [GW-1:0]   pick_idx;
    logic            pick_rw;
    logic [GW:0]     scan_idx;

    logic            in_data;
    logic            cmd_fire;
    logic            burst_end;

    // Select the granted requester's command fields and write data
    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = '0;
        sel_len   = '0;
        sel_rw    = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == GW'(i)) begin
                sel_valid = req_valid[i];
                sel_addr  = req_addr[22*i +: 22];
                sel_len   = req_len[7*i +: 7];
                sel_rw    = req_rw[i];
                sel_wdata = req_wdata[32*i +: 32];
            end
        end
    end

    // Find the first valid requester scanning from ptr upward with wrap;
    // the scan index carries one extra bit so ptr+k never overflows
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_rw    = 1'b0;
        scan_idx   = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = {1'b0, ptr} + (GW+1)'(k);
            if (scan_idx >= (GW+1)'(N))
                scan_idx = scan_idx - (GW+1)'(N);
            for (int i = 0; i < N; i++) begin
                if (!pick_found && scan_idx == (GW+1)'(i) && req_valid[i]) begin
                    pick_found = 1'b1;
                    pick_idx   = GW'(i);
                    pick_rw    = req_rw[i];
                end
            end
        end
    end

    assign in_data   = (state == DATA);
    assign cmd_fire  = (state == CMD) && sel_valid && mi_ready;
    // Only a terminal beat of the registered direction closes the burst
    assign burst_end = in_data && (rw_q ? (mi_rstb && mi_rlast) : (mi_wack && mi_wlast));

    // Arbitration FSM: grant in IDLE, issue in CMD, hold through DATA
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
            rw_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant <= pick_idx;
                        rw_q  <= pick_rw;
                        state <= CMD;
                    end
                end
                CMD: begin
                    if (cmd_fire)
                        state <= DATA;
                    else if (!sel_valid)
                        state <= IDLE;   // withdrawn request: ptr stays put
                end
                DATA: begin
                    if (burst_end) begin
                        state <= IDLE;
                        ptr   <= (grant == GW'(N-1)) ? '0 : grant + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Command passthrough and per-requester strobe steering
    always_comb begin
        mi_valid  = (state == CMD) && sel_valid;
        mi_addr   = (state == CMD) ? sel_addr : '0;
        mi_len    = (state == CMD) ? sel_len  : '0;
        mi_rw     = (state == CMD) ? sel_rw   : 1'b0;
        mi_wdata  = rst ? '0 : sel_wdata;
        req_rdata = mi_rdata;
        req_ready = '0;
        req_wack  = '0;
        req_wlast = '0;
        req_rstb  = '0;
        req_rlast = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == GW'(i)) begin
                req_ready[i] = cmd_fire;
                req_wack[i]  = in_data && !rw_q && mi_wack;
                req_wlast[i] = in_data && !rw_q && mi_wack && mi_wlast;
                req_rstb[i]  = in_data &&  rw_q && mi_rstb;
                req_rlast[i] = in_data &&  rw_q && mi_rstb && mi_rlast;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
